soc_test_ctrl: RTL

SOC_TEST_CTRL -- requirements
Module: soc_test_ctrl

---
 rtl/soc_test_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/soc_test_ctrl.sv
// soc_test_ctrl: sequences SoC resets for a test run and watches the tohost
// word to detect the end of the test.
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 begin a test (IDLE) or rerun it (DONE)
//   i_wr_en/addr/data       snooped SoC data-bus writes
//   o_soc_rst_n             per-channel active-low SoC resets, released in ascending order
//   o_running               high while the test runs
//   o_done/o_pass/o_timeout sticky result flags
//   o_fail_code             upper bits of the completing tohost write
//   o_cycle_count           cycles spent running, saturating
module soc_test_ctrl #(
  parameter int          NUM_RST        = 1,
  parameter int          RST_CYCLES     = 2,
  parameter int          STAGGER        = 0,
  parameter int          TIMEOUT_CYCLES = 0,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
  parameter int          CNT_W          = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [NUM_RST-1:0]    o_soc_rst_n,
  output logic                  o_running,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [DATA_WIDTH-2:0] o_fail_code,
  output logic [CNT_W-1:0]      o_cycle_count
);

  typedef enum logic [2:0] {ST_IDLE, ST_HOLD, ST_RELEASE, ST_RUN, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [31:0]           seq_q, seq_d;
  logic [NUM_RST-1:0]    rst_n_d;
  logic                  running_d, done_d, pass_d, timeout_d;
  logic [DATA_WIDTH-2:0] fail_d;
  logic [CNT_W-1:0]      cnt_d, cnt_inc;
  logic                  hit, timeout_hit;

  assign hit = i_wr_en && (i_wr_addr == ADDR_WIDTH'(TOHOST_ADDR)) && i_wr_data[0];

  assign cnt_inc = (&o_cycle_count) ? o_cycle_count : o_cycle_count + CNT_W'(1);

  // Compare against the count this RUN cycle produces, so the count shown in
  // DONE equals TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // State register and all registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      seq_q         <= '0;
      o_soc_rst_n   <= '0;
      o_running     <= 1'b0;
      o_done        <= 1'b0;
      o_pass        <= 1'b0;
      o_timeout     <= 1'b0;
      o_fail_code   <= '0;
      o_cycle_count <= '0;
    end else begin
      state_q       <= state_d;
      seq_q         <= seq_d;
      o_soc_rst_n   <= rst_n_d;
      o_running     <= running_d;
      o_done        <= done_d;
      o_pass        <= pass_d;
      o_timeout     <= timeout_d;
      o_fail_code   <= fail_d;
      o_cycle_count <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (i_start) state_d = ST_HOLD;
      ST_HOLD:    if (seq_q == 32'(RST_CYCLES - 1)) state_d = ST_RELEASE;
      ST_RELEASE: if (&o_soc_rst_n) state_d = ST_RUN;
      ST_RUN:     if (hit || timeout_hit) state_d = ST_DONE;
      ST_DONE:    if (i_start) state_d = ST_HOLD;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    seq_d     = seq_q;
    rst_n_d   = o_soc_rst_n;
    running_d = (state_d == ST_RUN);
    done_d    = o_done;
    pass_d    = o_pass;
    timeout_d = o_timeout;
    fail_d    = o_fail_code;
    cnt_d     = o_cycle_count;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        rst_n_d = '0;
        if (i_start) begin
          seq_d     = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          fail_d    = '0;
          cnt_d     = '0;
        end
      end
      ST_HOLD: begin
        rst_n_d = '0;
        seq_d   = seq_q + 32'd1;
        if (state_d == ST_RELEASE) begin
          // seq restarts as the RELEASE cycle index; channels with a zero
          // offset come out of reset on entry.
          seq_d = '0;
          for (int unsigned k = 0; k < NUM_RST; k++)
            if (k * 32'(STAGGER) == 32'd0) rst_n_d[k] = 1'b1;
        end
      end
      ST_RELEASE: begin
        seq_d = seq_q + 32'd1;
        for (int unsigned k = 0; k < NUM_RST; k++)
          if (seq_d == k * 32'(STAGGER)) rst_n_d[k] = 1'b1;
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (hit) begin
          rst_n_d   = '0;
          done_d    = 1'b1;
          pass_d    = (i_wr_data == DATA_WIDTH'(1));
          timeout_d = 1'b0;
          fail_d    = i_wr_data[DATA_WIDTH-1:1];
        end else if (timeout_hit) begin
          rst_n_d   = '0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          fail_d    = '0;
        end
      end
      default: rst_n_d = '0;
    endcase
  end

endmodule
